multicycle_ctl: RTL and testbench
=================================

// Module: multicycle_ctl
// PURPOSE
//   Parametrised multi-cycle MIPS control unit: five-state FSM (IF/ID/EX/MEM/WB) driving datapath
//   muxes, ALU op, PC/IR/register/memory enables. Adds a memory-ready stall handshake, bne/ori,
//   illegal-opcode detection and per-instruction completion pulse. Sits between IR opcode field and datapath.
// PARAMETERS
//   OP_W     6   opcode field width
//   ALUOP_W  2   alu_op width (0=ADD, 1=SUB, 2=FUNCT, 3=OR); must be >=2
//   CNT_W    32  perf counter width (used only with MCTL_PERF_EN)
// PORTS
//   clk         in   1        clock, all state on rising edge
//   rst         in   1        asynchronous, active-low reset
//   op          in   OP_W     opcode from IR (valid from ID onward)
//   zero        in   1        ALU zero flag
//   mem_ready   in   1        memory access completes this cycle
//   pc_write    out  1        PC load enable
//   pc_src      out  2        0=ALU result, 1=ALUOut (branch target), 2=jump target
//   ir_write    out  1        IR load enable
//   mem_read    out  1        memory read request
//   mem_write   out  1        memory write request
//   i_or_d      out  1        memory address: 0=PC, 1=ALUOut
//   alu_src_a   out  1        0=PC, 1=rs
//   alu_src_b   out  2        0=rt, 1=const 4, 2=sign-ext imm, 3=imm<<2
//   alu_op      out  ALUOP_W  ALU control class
//   reg_write   out  1        register file write enable
//   reg_dst     out  1        1=rd, 0=rt
//   mem_to_reg  out  1        1=MDR, 0=ALUOut
//   instr_done  out  1        one-cycle pulse on the last cycle of each instruction
//   illegal     out  1        one-cycle pulse in ID on unknown opcode
//   state       out  3        current state (debug)
// BEHAVIOUR
//   States: IF=0, ID=1, EX=2, MEM=3, WB=4. Opcode latched into op_q on ID; EX/MEM/WB decode op_q.
//   Outputs are combinational from state/op_q/zero/mem_ready; all default 0 unless listed.
//   IF : mem_read=1, i_or_d=0, alu_src_b=1, alu_op=ADD. Hold while !mem_ready; on mem_ready:
//        ir_write=1, pc_write=1, pc_src=0, -> ID. Latency 1 cycle min, +N wait cycles.
//   ID : alu_src_b=3, alu_op=ADD (branch target). j: pc_write=1, pc_src=2, instr_done=1 -> IF.
//        Unknown op: illegal=1, instr_done=1 -> IF (treated as nop). R/addi/ori/lw/sw/beq/bne -> EX.
//   EX : R: src_a=1, src_b=0, FUNCT -> WB. addi/lw/sw: src_a=1, src_b=2, ADD; lw/sw -> MEM, addi -> WB.
//        ori: src_a=1, src_b=2, OR -> WB. beq/bne: src_a=1, src_b=0, SUB, pc_src=1,
//        pc_write = zero (beq) / !zero (bne), instr_done=1 -> IF.
//   MEM: i_or_d=1; lw: mem_read=1, sw: mem_write=1; request held until mem_ready.
//        On mem_ready: lw -> WB; sw -> IF with instr_done=1.
//   WB : reg_write=1, reg_dst=(R-type), mem_to_reg=(lw), instr_done=1 -> IF.
//   Cycle counts (zero wait): j 2, beq/bne 3, sw 4, R/addi/ori 4, lw 5.
//   Reset: async on rst low -> state=IF, op_q=0; while rst low every output forced 0 (state=0).
//     First IF cycle after release issues mem_read. Reset mid-instruction abandons it; no writes leak.
//   mem_ready ignored outside IF/MEM. Every write enable is single-cycle; no enable asserts twice per instr.
//   Illegal state encodings (5-7) -> IF next cycle, outputs 0.
// CONFIGURATION
//   MCTL_PERF_EN defined: adds outputs cyc_cnt[CNT_W] (increments every clock after reset) and
//     instr_cnt[CNT_W] (increments on instr_done); both wrap modulo 2^CNT_W, cleared by rst.
//   Undefined: ports and counters absent; CNT_W unused.
// STRUCTURE
//   Package mctl_pkg: state encoding, opcode localparams (R=000000, j=000010, beq=000100,
//     bne=000101, addi=001000, ori=001101, lw=100011, sw=101011), alu_op codes, pc_src/alu_src_b codes.
//   Sub-module mctl_decode: combinational op -> one-hot instruction class + legal flag; FSM in top.
// TESTING
//   add (op=0), mem_ready=1 -> states IF,ID,EX,WB; reg_write=1 & reg_dst=1 only in WB; instr_done cycle 4.
//   lw with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_read steady, WB mem_to_reg=1, 8 total.
//   beq zero=1 then zero=0 -> pc_write=1 pc_src=1 in EX only first case; bne inverse; both 3 cycles.
//   op=111111 -> illegal pulse in ID, no write enables, back in IF next cycle.
//   rst low during sw MEM -> outputs 0 immediately, mem_write never reaches 1 after, IF on release.
//   MCTL_PERF_EN: 3 instructions (j, add, lw) zero-wait -> instr_cnt=3, cyc_cnt=11 at final instr_done+1.

Source files
------------

// File: rtl/mctl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// ALU op classes, datapath mux codes and the decoded instruction-class vector.
package mctl_pkg;

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;

  localparam logic [1:0] AluAdd   = 2'd0;
  localparam logic [1:0] AluSub   = 2'd1;
  localparam logic [1:0] AluFunct = 2'd2;
  localparam logic [1:0] AluOr    = 2'd3;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  localparam logic [1:0] SrcBRt    = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  typedef struct packed {
    logic r;
    logic j;
    logic beq;
    logic bne;
    logic addi;
    logic ori;
    logic lw;
    logic sw;
  } instr_cls_t;

endpackage

// File: rtl/mctl_decode.sv
// Combinational opcode decoder: one-hot instruction class plus a legal flag.
module mctl_decode
  import mctl_pkg::*;
#(
  parameter int unsigned OP_W = 6
) (
  input  logic [OP_W-1:0] op_i,
  output instr_cls_t      cls_o,
  output logic            legal_o
);

  always_comb begin
    cls_o = '0;
    case (op_i)
      OP_W'(OpR):    cls_o.r    = 1'b1;
      OP_W'(OpJ):    cls_o.j    = 1'b1;
      OP_W'(OpBeq):  cls_o.beq  = 1'b1;
      OP_W'(OpBne):  cls_o.bne  = 1'b1;
      OP_W'(OpAddi): cls_o.addi = 1'b1;
      OP_W'(OpOri):  cls_o.ori  = 1'b1;
      OP_W'(OpLw):   cls_o.lw   = 1'b1;
      OP_W'(OpSw):   cls_o.sw   = 1'b1;
      default:       cls_o      = '0;
    endcase
  end

  assign legal_o = |cls_o;

endmodule

// File: rtl/multicycle_ctl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with memory-ready stalls.
// Define MCTL_PERF_EN to add cycle and retired-instruction counters.
module multicycle_ctl
  import mctl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [OP_W-1:0]    op_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic [1:0]         pc_src_o,
  output logic               ir_write_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               i_or_d_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               instr_done_o,
  output logic               illegal_o,
  output logic [2:0]         state_o
`ifdef MCTL_PERF_EN
  ,
  output logic [CNT_W-1:0]   cyc_cnt_o,
  output logic [CNT_W-1:0]   instr_cnt_o
`endif
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [OP_W-1:0] dec_op;
  instr_cls_t      cls;
  logic            legal;

  // ID decodes the live IR field; later states use the opcode captured in ID.
  assign dec_op = (state_q == StId) ? op_i : op_q;

  mctl_decode #(
    .OP_W(OP_W)
  ) u_decode (
    .op_i   (dec_op),
    .cls_o  (cls),
    .legal_o(legal)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIf;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Every output is held low while reset is asserted, including IF's read request.
  always_comb begin
    state_d      = StIf;
    op_d         = op_q;
    pc_write_o   = 1'b0;
    pc_src_o     = PcSrcAlu;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    i_or_d_o     = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SrcBRt;
    alu_op_o     = ALUOP_W'(AluAdd);
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    if (rst_ni) begin
      case (state_q)
        StIf: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = SrcBFour;
          state_d     = StIf;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            state_d    = StId;
          end
        end
        StId: begin
          op_d        = op_i;
          alu_src_b_o = SrcBImmSh;
          if (cls.j) begin
            pc_write_o   = 1'b1;
            pc_src_o     = PcSrcJump;
            instr_done_o = 1'b1;
          end else if (!legal) begin
            illegal_o    = 1'b1;
            instr_done_o = 1'b1;
          end else begin
            state_d = StEx;
          end
        end
        StEx: begin
          if (cls.r) begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALUOP_W'(AluFunct);
            state_d     = StWb;
          end else if (cls.addi || cls.lw || cls.sw) begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SrcBImm;
            state_d     = cls.addi ? StWb : StMem;
          end else if (cls.ori) begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SrcBImm;
            alu_op_o    = ALUOP_W'(AluOr);
            state_d     = StWb;
          end else if (cls.beq || cls.bne) begin
            alu_src_a_o  = 1'b1;
            alu_op_o     = ALUOP_W'(AluSub);
            pc_src_o     = PcSrcAluOut;
            pc_write_o   = cls.beq ? zero_i : !zero_i;
            instr_done_o = 1'b1;
          end
        end
        StMem: begin
          i_or_d_o    = 1'b1;
          mem_read_o  = cls.lw;
          mem_write_o = cls.sw;
          state_d     = StMem;
          if (mem_ready_i) begin
            state_d      = cls.lw ? StWb : StIf;
            instr_done_o = cls.sw;
          end
        end
        StWb: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = cls.r;
          mem_to_reg_o = cls.lw;
          instr_done_o = 1'b1;
        end
        default: state_d = StIf;
      endcase
    end
  end

  assign state_o = state_q;

`ifdef MCTL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_q, instr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
      if (instr_done_o) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign cyc_cnt_o   = cyc_cnt_q;
  assign instr_cnt_o = instr_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_ctl.sv
// Bench for multicycle_ctl: per-instruction expected cycle traces built from the
// instruction-level timing rules, replayed against the DUT with random stalls.
module tb_multicycle_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal;
  logic [2:0] state;
`ifdef MCTL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  multicycle_ctl #(
    .OP_W   (6),
    .ALUOP_W(2),
    .CNT_W  (32)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .op_i        (op),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .pc_write_o  (pc_write),
    .pc_src_o    (pc_src),
    .ir_write_o  (ir_write),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .i_or_d_o    (i_or_d),
    .alu_src_a_o (alu_src_a),
    .alu_src_b_o (alu_src_b),
    .alu_op_o    (alu_op),
    .reg_write_o (reg_write),
    .reg_dst_o   (reg_dst),
    .mem_to_reg_o(mem_to_reg),
    .instr_done_o(instr_done),
    .illegal_o   (illegal),
    .state_o     (state)
`ifdef MCTL_PERF_EN
    ,
    .cyc_cnt_o   (cyc_cnt),
    .instr_cnt_o (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [19:0] act;
  assign act = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, alu_src_a, alu_src_b,
                alu_op, reg_write, reg_dst, mem_to_reg, instr_done, illegal, state};

  typedef struct packed {
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [19:0] exp;
  } cyc_t;

  cyc_t        q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc_model = 0;
  int unsigned done_model = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] vec(input logic pcw, input logic [1:0] pcs, input logic irw,
                                      input logic mr, input logic mw, input logic iod,
                                      input logic sa, input logic [1:0] sb, input logic [1:0] aop,
                                      input logic rw, input logic rd, input logic m2r,
                                      input logic done, input logic ill, input logic [2:0] st);
    return {pcw, pcs, irw, mr, mw, iod, sa, sb, aop, rw, rd, m2r, done, ill, st};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  // Expected trace: IF (+iw stalls), ID, then class-specific EX/MEM(+mw stalls)/WB cycles.
  task automatic add_instr(input logic [5:0] o, input logic z, input int iw, input int mw);
    logic is_r, is_j, is_beq, is_bne, is_addi, is_ori, is_lw, is_sw, last;
    is_r = (o == 6'b000000); is_j = (o == 6'b000010);
    is_beq = (o == 6'b000100); is_bne = (o == 6'b000101);
    is_addi = (o == 6'b001000); is_ori = (o == 6'b001101);
    is_lw = (o == 6'b100011); is_sw = (o == 6'b101011);
    for (int k = 0; k <= iw; k++) begin
      last = (k == iw);
      q.push_back('{rnd_op(), rnd_bit(), last,
                    vec(last, 2'd0, last, 1, 0, 0, 0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 3'd0)});
    end
    if (is_j) begin
      q.push_back('{o, rnd_bit(), rnd_bit(),
                    vec(1, 2'd2, 0, 0, 0, 0, 0, 2'd3, 2'd0, 0, 0, 0, 1, 0, 3'd1)});
      return;
    end
    if (!(is_r || is_beq || is_bne || is_addi || is_ori || is_lw || is_sw)) begin
      q.push_back('{o, rnd_bit(), rnd_bit(),
                    vec(0, 2'd0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 0, 0, 0, 1, 1, 3'd1)});
      return;
    end
    q.push_back('{o, rnd_bit(), rnd_bit(),
                  vec(0, 2'd0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 0, 0, 0, 0, 0, 3'd1)});
    if (is_beq || is_bne) begin
      q.push_back('{rnd_op(), z, rnd_bit(),
                    vec(is_beq ? z : !z, 2'd1, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0, 0, 1, 0, 3'd2)});
      return;
    end
    if (is_r)
      q.push_back('{rnd_op(), rnd_bit(), rnd_bit(),
                    vec(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 0, 0, 0, 0, 0, 3'd2)});
    else
      q.push_back('{rnd_op(), rnd_bit(), rnd_bit(),
                    vec(0, 2'd0, 0, 0, 0, 0, 1, 2'd2, is_ori ? 2'd3 : 2'd0, 0, 0, 0, 0, 0, 3'd2)});
    if (is_lw || is_sw) begin
      for (int k = 0; k <= mw; k++) begin
        last = (k == mw);
        q.push_back('{rnd_op(), rnd_bit(), last,
                      vec(0, 2'd0, 0, is_lw, is_sw, 1, 0, 2'd0, 2'd0, 0, 0, 0, is_sw && last, 0,
                          3'd3)});
      end
      if (is_sw) return;
    end
    q.push_back('{rnd_op(), rnd_bit(), rnd_bit(),
                  vec(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, is_r, is_lw, 1, 0, 3'd4)});
  endtask

  // Entered just after a rising edge; leaves just after the rising edge ending the last cycle.
  task automatic run_queue(input int n);
    cyc_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      op = e.op; zero = e.z; mem_ready = e.mr;
      @(negedge clk);
      check_eq($sformatf("trace_s%0d", e.exp[2:0]), 32'(act), 32'(e.exp));
      cyc_model++;
      if (e.exp[4]) done_model++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic z, input int iw, input int mw);
    add_instr(o, z, iw, mw);
    run_queue(q.size());
  endtask

  localparam logic [5:0] Ops[8] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h23, 6'h2b};
  localparam logic [5:0] BadOps[4] = '{6'h3f, 6'h01, 6'h10, 6'h30};

  initial begin
    logic [5:0] o;
    // Reset: every output low, state IF.
    mem_ready = 1'b1;
    #2;
    check_eq("rst_outputs", 32'(act), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr(6'h00, 1'b0, 0, 0);                // add, 4 cycles
    run_instr(6'h23, 1'b0, 0, 3);                // lw with 3 MEM stalls, 8 cycles
    run_instr(6'h04, 1'b1, 0, 0);                // beq taken
    run_instr(6'h04, 1'b0, 0, 0);                // beq not taken
    run_instr(6'h05, 1'b1, 0, 0);                // bne not taken
    run_instr(6'h05, 1'b0, 0, 0);                // bne taken
    run_instr(6'h3f, 1'b0, 0, 0);                // illegal opcode
    run_instr(6'h0d, 1'b0, 2, 0);                // ori with IF stalls

    // Reset in the middle of a stalled sw MEM access.
    add_instr(6'h2b, 1'b0, 0, 5);
    run_queue(5);
    mem_ready = 1'b0;
    #1;
    check_eq("sw_mem_pre", 32'(mem_write), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_sw", 32'(act), 32'h0);
    q.delete();
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold", 32'(act), 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_model = 0;
    done_model = 0;

    // Counters from reset: j + add + lw at zero wait = 11 cycles, 3 instructions.
    run_instr(6'h02, 1'b0, 0, 0);
    run_instr(6'h00, 1'b0, 0, 0);
    run_instr(6'h23, 1'b0, 0, 0);
`ifdef MCTL_PERF_EN
    check_eq("cyc_cnt_dir", cyc_cnt, 32'(cyc_model));
    check_eq("instr_cnt_dir", instr_cnt, 32'(done_model));
`endif

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) o = BadOps[$urandom_range(0, 3)];
      else o = Ops[$urandom_range(0, 7)];
      run_instr(o, rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 3));
    end
`ifdef MCTL_PERF_EN
    check_eq("cyc_cnt_rnd", cyc_cnt, 32'(cyc_model));
    check_eq("instr_cnt_rnd", instr_cnt, 32'(done_model));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
